// File: rtl/adt7420_pkg.sv
// adt7420_pkg: shared address, ACK/NACK levels and responder state encoding
package adt7420_pkg;
    localparam logic [6:0] ADT7420_ADDR = 7'h4B;
    localparam logic       I2C_ACK      = 1'b0;
    localparam logic       I2C_NACK     = 1'b1;
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_TX_BYTE, S_TX_ACK, S_RX_BYTE, S_RX_ACK, S_IGNORE
    } state_t;
endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: 2-flop synchronizers for scl/sda plus edge and START/STOP pulses
// clk_100MHz/reset: system clock, sync active-high reset (flops preset to 1)
// i_scl/i_sda: raw bus pins; o_sda_s: synchronized sda
// o_scl_rise/o_scl_fall/o_start_det/o_stop_det: one-cycle event pulses
module i2c_bus_sync (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda_s,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start_det,
    output logic o_stop_det
);
    // [0] metastability flop, [1] synchronized value, [2] previous synchronized value
    logic [2:0] r_scl;
    logic [2:0] r_sda;
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_scl <= 3'b111;
            r_sda <= 3'b111;
        end else begin
            r_scl <= {r_scl[1:0], i_scl};
            r_sda <= {r_sda[1:0], i_sda};
        end
    end
    assign o_sda_s     = r_sda[1];
    assign o_scl_rise  = r_scl[1] & ~r_scl[2];
    assign o_scl_fall  = ~r_scl[1] & r_scl[2];
    assign o_start_det = r_scl[1] & r_scl[2] & ~r_sda[1] & r_sda[2];
    assign o_stop_det  = r_scl[1] & r_scl[2] & r_sda[1] & ~r_sda[2];
endmodule

// File: rtl/adt7420_i2c_responder.sv
// adt7420_i2c_responder: I2C target serving a 16-bit temperature register and a write pointer
// clk_100MHz/reset: system clock, sync active-high reset; scl/sda: I2C bus (sda open-drain)
// temp_data: value snapshotted at address match; busy/addr_match/read_done: status
// pointer: last byte written by the master
module adt7420_i2c_responder
    import adt7420_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR = ADT7420_ADDR
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic        scl,
    inout  wire         sda,
    input  logic [15:0] temp_data,
    output logic        busy,
    output logic        addr_match,
    output logic        read_done,
    output logic [7:0]  pointer
);
    logic w_sda_s, w_rise, w_fall, w_start, w_stop;
    i2c_bus_sync u_sync (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .i_scl      (scl),
        .i_sda      (sda),
        .o_sda_s    (w_sda_s),
        .o_scl_rise (w_rise),
        .o_scl_fall (w_fall),
        .o_start_det(w_start),
        .o_stop_det (w_stop)
    );
    state_t      r_state, w_state;
    logic [3:0]  r_cnt, w_cnt;
    logic [7:0]  r_shift, w_shift;
    logic [15:0] r_hold, w_hold;
    logic [7:0]  r_tx, w_tx;
    logic        r_sel, w_sel;
    logic        r_rw, w_rw;
    logic        r_sda_low, w_sda_low;
    logic        r_busy, w_busy;
    logic        r_addr_match, w_addr_match;
    logic        r_read_done, w_read_done;
    logic [7:0]  r_pointer, w_pointer;
    logic [7:0]  w_byte;
    assign w_byte = {r_shift[6:0], w_sda_s};
    // In ACK states r_cnt=0 waits for the fall that starts the ACK, r_cnt=1 for the fall that ends it.
    // In S_TX_BYTE r_cnt counts bits already driven; r_sel=1 means the LSB is next.
    always_comb begin
        w_state      = r_state;
        w_cnt        = r_cnt;
        w_shift      = r_shift;
        w_hold       = r_hold;
        w_tx         = r_tx;
        w_sel        = r_sel;
        w_rw         = r_rw;
        w_sda_low    = r_sda_low;
        w_busy       = r_busy;
        w_addr_match = 1'b0;
        w_read_done  = 1'b0;
        w_pointer    = r_pointer;
        if (w_start) begin
            w_state   = S_ADDR;
            w_cnt     = 4'd0;
            w_sda_low = 1'b0;
        end else if (w_stop) begin
            w_state   = S_IDLE;
            w_sda_low = 1'b0;
            w_busy    = 1'b0;
        end else begin
            case (r_state)
                S_ADDR: if (w_rise) begin
                    w_shift = w_byte;
                    w_cnt   = r_cnt + 4'd1;
                    if (r_cnt == 4'd7) begin
                        w_cnt = 4'd0;
                        w_rw  = w_byte[0];
                        if (w_byte[7:1] == I2C_ADDR) begin
                            w_state      = S_ADDR_ACK;
                            w_addr_match = 1'b1;
                            w_busy       = 1'b1;
                            w_hold       = temp_data;
                        end else begin
                            w_state = S_IGNORE;
                            w_busy  = 1'b0;
                        end
                    end
                end
                S_ADDR_ACK, S_RX_ACK: if (w_fall) begin
                    if (r_cnt == 4'd0) begin
                        w_sda_low = (I2C_ACK == 1'b0);
                        w_cnt     = 4'd1;
                    end else if (r_state == S_RX_ACK || !r_rw) begin
                        w_sda_low = 1'b0;
                        w_cnt     = 4'd0;
                        w_state   = S_RX_BYTE;
                    end else begin
                        w_tx      = r_hold[15:8];
                        w_sel     = 1'b1;
                        w_sda_low = ~r_hold[15];
                        w_cnt     = 4'd1;
                        w_state   = S_TX_BYTE;
                    end
                end
                S_TX_BYTE: if (w_fall) begin
                    if (r_cnt == 4'd8) begin
                        w_sda_low = 1'b0;
                        w_state   = S_TX_ACK;
                    end else begin
                        w_sda_low = ~r_tx[3'd7 - r_cnt[2:0]];
                        w_cnt     = r_cnt + 4'd1;
                    end
                end
                S_TX_ACK: if (w_rise) begin
                    if (w_sda_s == I2C_ACK) begin
                        w_tx    = r_sel ? r_hold[7:0] : r_hold[15:8];
                        w_sel   = ~r_sel;
                        w_cnt   = 4'd0;
                        w_state = S_TX_BYTE;
                    end else begin
                        w_read_done = 1'b1;
                        w_busy      = 1'b0;
                        w_state     = S_IGNORE;
                    end
                end
                S_RX_BYTE: if (w_rise) begin
                    w_shift = w_byte;
                    w_cnt   = r_cnt + 4'd1;
                    if (r_cnt == 4'd7) begin
                        w_pointer = w_byte;
                        w_cnt     = 4'd0;
                        w_state   = S_RX_ACK;
                    end
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_shift      <= 8'h00;
            r_hold       <= 16'h0000;
            r_tx         <= 8'h00;
            r_sel        <= 1'b0;
            r_rw         <= 1'b0;
            r_sda_low    <= 1'b0;
            r_busy       <= 1'b0;
            r_addr_match <= 1'b0;
            r_read_done  <= 1'b0;
            r_pointer    <= 8'h00;
        end else begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_shift      <= w_shift;
            r_hold       <= w_hold;
            r_tx         <= w_tx;
            r_sel        <= w_sel;
            r_rw         <= w_rw;
            r_sda_low    <= w_sda_low;
            r_busy       <= w_busy;
            r_addr_match <= w_addr_match;
            r_read_done  <= w_read_done;
            r_pointer    <= w_pointer;
        end
    end
    assign sda        = r_sda_low ? 1'b0 : 1'bz;
    assign busy       = r_busy;
    assign addr_match = r_addr_match;
    assign read_done  = r_read_done;
    assign pointer    = r_pointer;
endmodule

// File: tb/tb_adt7420_i2c_responder.sv
// tb_adt7420_i2c_responder: bit-banged I2C master with table, random and corner-case checks
module tb_adt7420_i2c_responder;
    localparam int Q = 5;
    localparam logic [6:0] ADDR = 7'h4B;
    logic        clk_100MHz = 1'b0;
    logic        reset;
    logic        m_scl;
    logic        m_sda_low;
    logic [15:0] temp_data;
    logic        busy, addr_match, read_done;
    logic [7:0]  pointer;
    wire         sda;
    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);
    always #5 clk_100MHz = ~clk_100MHz;
    adt7420_i2c_responder dut (
        .clk_100MHz(clk_100MHz),
        .reset     (reset),
        .scl       (m_scl),
        .sda       (sda),
        .temp_data (temp_data),
        .busy      (busy),
        .addr_match(addr_match),
        .read_done (read_done),
        .pointer   (pointer)
    );
    int checks = 0;
    int errors = 0;
    int am_cnt = 0;
    int rd_cnt = 0;
    int viol = 0;
    logic in_cond = 1'b0;
    logic p_scl = 1'b1;
    logic p_sda = 1'b1;
    always @(posedge clk_100MHz) begin
        if (addr_match) am_cnt++;
        if (read_done) rd_cnt++;
        if (!in_cond && m_scl && p_scl && sda !== p_sda) viol++;
        p_scl = m_scl;
        p_sda = sda;
    end
    typedef struct {
        logic        rd;
        logic [6:0]  addr;
        logic [15:0] temp;
        logic [15:0] temp2;
        int          n;
        logic [15:0] wd;
        logic        exp_ack;
        logic [31:0] exp_rd;
        logic [7:0]  exp_ptr;
    } vec_t;
    vec_t tbl[7];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic wait_q();
        repeat (Q) @(negedge clk_100MHz);
    endtask
    task automatic i2c_start();
        in_cond = 1'b1;
        m_sda_low = 1'b0;
        wait_q();
        m_scl = 1'b1;
        wait_q();
        m_sda_low = 1'b1;
        wait_q();
        m_scl = 1'b0;
        wait_q();
        in_cond = 1'b0;
    endtask
    task automatic i2c_stop();
        in_cond = 1'b1;
        m_sda_low = 1'b1;
        wait_q();
        m_scl = 1'b1;
        wait_q();
        m_sda_low = 1'b0;
        wait_q();
        in_cond = 1'b0;
    endtask
    task automatic write_bit(input logic b);
        m_sda_low = ~b;
        wait_q();
        m_scl = 1'b1;
        wait_q();
        wait_q();
        m_scl = 1'b0;
        wait_q();
    endtask
    task automatic read_bit(output logic b);
        m_sda_low = 1'b0;
        wait_q();
        m_scl = 1'b1;
        wait_q();
        b = sda;
        wait_q();
        m_scl = 1'b0;
        wait_q();
    endtask
    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask
    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
        write_bit(ack);
    endtask
    // Reference: a matched read streams MSB, LSB, MSB, LSB of the snapshot; an ignored bus reads all ones.
    function automatic logic [31:0] model_rd(input logic [15:0] t, input logic m);
        return m ? {t, t} : 32'hFFFF_FFFF;
    endfunction
    task automatic run_txn(input vec_t v, input string nm);
        logic ack;
        logic [7:0] d;
        int am0, rd0;
        am0 = am_cnt;
        rd0 = rd_cnt;
        temp_data = v.temp;
        i2c_start();
        write_byte({v.addr, v.rd}, ack);
        chk($sformatf("%s addr_ack", nm), 32'(ack), 32'(v.exp_ack));
        chk($sformatf("%s busy_mid", nm), 32'(busy), 32'(!v.exp_ack));
        temp_data = v.temp2;
        for (int i = 0; i < v.n; i++) begin
            if (v.rd) begin
                read_byte(d, i == v.n - 1);
                chk($sformatf("%s rd_byte%0d", nm, i), 32'(d), 32'(v.exp_rd[31 - 8 * i -: 8]));
            end else begin
                write_byte(i == 0 ? v.wd[15:8] : v.wd[7:0], ack);
                chk($sformatf("%s wr_ack%0d", nm, i), 32'(ack), 32'(v.exp_ack));
            end
        end
        i2c_stop();
        wait_q();
        chk($sformatf("%s busy_end", nm), 32'(busy), 32'd0);
        chk($sformatf("%s pointer", nm), 32'(pointer), 32'(v.exp_ptr));
        chk($sformatf("%s addr_match_cnt", nm), 32'(am_cnt - am0), 32'(!v.exp_ack));
        chk($sformatf("%s read_done_cnt", nm), 32'(rd_cnt - rd0), 32'(v.rd && !v.exp_ack));
    endtask
    initial begin
        logic ack, b;
        logic [7:0] d;
        logic [4:0] bits;
        logic [7:0] ptr_m;
        int am0, rd0;
        vec_t v;
        tbl[0] = '{1'b1, 7'h4B, 16'h2880, 16'h2880, 2, 16'h0000, 1'b0, 32'h2880_2880, 8'h00};
        tbl[1] = '{1'b1, 7'h48, 16'h2880, 16'h2880, 2, 16'h0000, 1'b1, 32'hFFFF_FFFF, 8'h00};
        tbl[2] = '{1'b0, 7'h4B, 16'h0000, 16'h0000, 1, 16'h0300, 1'b0, 32'h0000_0000, 8'h03};
        tbl[3] = '{1'b1, 7'h4B, 16'h2880, 16'h1234, 3, 16'h0000, 1'b0, 32'h2880_2880, 8'h03};
        tbl[4] = '{1'b0, 7'h4A, 16'h0000, 16'h0000, 1, 16'h7700, 1'b1, 32'h0000_0000, 8'h03};
        tbl[5] = '{1'b0, 7'h4B, 16'h0000, 16'h0000, 2, 16'hA55A, 1'b0, 32'h0000_0000, 8'h5A};
        tbl[6] = '{1'b1, 7'h4B, 16'hF00F, 16'h0000, 4, 16'h0000, 1'b0, 32'hF00F_F00F, 8'h5A};
        reset = 1'b1;
        m_scl = 1'b1;
        m_sda_low = 1'b0;
        temp_data = 16'h0000;
        repeat (5) @(negedge clk_100MHz);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset addr_match", 32'(addr_match), 32'd0);
        chk("reset read_done", 32'(read_done), 32'd0);
        chk("reset pointer", 32'(pointer), 32'd0);
        chk("reset sda", 32'(sda), 32'd1);
        reset = 1'b0;
        wait_q();
        for (int i = 0; i < 7; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));
        am0 = am_cnt;
        rd0 = rd_cnt;
        temp_data = 16'h2880;
        i2c_start();
        write_byte({ADDR, 1'b1}, ack);
        chk("rstart addr_ack1", 32'(ack), 32'd0);
        read_byte(d, 1'b0);
        chk("rstart msb1", 32'(d), 32'h28);
        temp_data = 16'h5AC3;
        i2c_start();
        write_byte({ADDR, 1'b1}, ack);
        chk("rstart addr_ack2", 32'(ack), 32'd0);
        read_byte(d, 1'b1);
        chk("rstart msb2", 32'(d), 32'h5A);
        i2c_stop();
        wait_q();
        chk("rstart addr_match_cnt", 32'(am_cnt - am0), 32'd2);
        chk("rstart read_done_cnt", 32'(rd_cnt - rd0), 32'd1);
        temp_data = 16'h2800;
        i2c_start();
        write_byte({ADDR, 1'b1}, ack);
        read_byte(d, 1'b0);
        chk("midrst msb", 32'(d), 32'h28);
        for (int i = 0; i < 3; i++) read_bit(b);
        chk("midrst sda_driven", 32'(sda), 32'd0);
        reset = 1'b1;
        @(posedge clk_100MHz);
        #1;
        chk("midrst sda_released", 32'(sda), 32'd1);
        @(negedge clk_100MHz);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst pointer", 32'(pointer), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            read_bit(b);
            bits = {bits[3:0], b};
        end
        chk("midrst ignored_bits", 32'(bits), 32'h1F);
        i2c_stop();
        wait_q();
        ptr_m = 8'h00;
        for (int k = 0; k < 20; k++) begin
            logic m;
            m = 1'($urandom_range(0, 1));
            v.addr = m ? ADDR : 7'($urandom_range(0, 127));
            if (v.addr == ADDR && !m) v.addr = ADDR ^ 7'h01;
            v.rd = 1'($urandom_range(0, 1));
            v.temp = 16'($urandom);
            v.temp2 = 16'($urandom);
            v.wd = 16'($urandom);
            v.n = v.rd ? $urandom_range(1, 4) : $urandom_range(1, 2);
            if (!v.rd && m) ptr_m = (v.n == 1) ? v.wd[15:8] : v.wd[7:0];
            v.exp_ack = !m;
            v.exp_rd = model_rd(v.temp, m);
            v.exp_ptr = ptr_m;
            run_txn(v, $sformatf("rnd%0d", k));
        end
        chk("sda_stable_scl_high", 32'(viol), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/adt7420_i2c_responder.md
ADT7420_I2C_RESPONDER -- requirements
Module: adt7420_i2c_responder

Interface
REQ-001 Parameter I2C_ADDR, default 7'h4B, the 7-bit target address this block answers to.
REQ-002 clk_100MHz  input  1  system clock, single clock domain, all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 scl  input  1  I2C clock from the bus master; asynchronous to clk_100MHz.
REQ-005 sda  inout  1  I2C data, open-drain: driven 1'b0 or 1'bz only, never 1'b1.
REQ-006 temp_data  input  16  temperature register value; [15:8] is MSB, [7:0] is LSB.
REQ-007 busy  output  1  high from an address-matching START until STOP or NACK release.
REQ-008 addr_match  output  1  one-cycle pulse when the received address equals I2C_ADDR.
REQ-009 read_done  output  1  one-cycle pulse when the master NACKs a transmitted byte.
REQ-010 pointer  output  8  last data byte received in a write transaction.

Function
REQ-011 scl and sda SHALL pass through a 2-flop synchronizer; edge detection uses the synchronized values (pin-to-action latency 3 clocks).
REQ-012 START is sda falling while scl is high; STOP is sda rising while scl is high; both are detected in every state, including mid-byte.
REQ-013 START (including repeated START) SHALL go to S_ADDR, clear the bit counter, and release sda.
REQ-014 STOP SHALL go to S_IDLE, release sda, and clear busy.
REQ-015 States: S_IDLE, S_ADDR, S_ADDR_ACK, S_TX_BYTE, S_TX_ACK, S_RX_BYTE, S_RX_ACK, S_IGNORE.
REQ-016 S_ADDR SHALL shift sda MSB-first on 8 scl rising edges (7 address bits, then R/W).
REQ-017 On address match: pulse addr_match, assert busy, and snapshot temp_data into a 16-bit hold register; enter S_ADDR_ACK. On mismatch: enter S_IGNORE with sda released until the next START or STOP.
REQ-018 S_ADDR_ACK SHALL drive sda low from the scl falling edge after bit 8 until the next scl falling edge.
REQ-019 After the ACK: R/W=1 goes to S_TX_BYTE with the MSB from the hold register; R/W=0 goes to S_RX_BYTE.
REQ-020 S_TX_BYTE SHALL update sda only on scl falling edges, MSB-first: drive low for 0, release for 1; after bit 0 it releases sda and enters S_TX_ACK.
REQ-021 S_TX_ACK SHALL sample sda on the scl rising edge. Low (ACK) loads the next byte: MSB then LSB, then wrap to MSB. High (NACK) pulses read_done and enters S_IGNORE with sda released.
REQ-022 S_RX_BYTE SHALL shift 8 bits on scl rising edges, load pointer, then go to S_RX_ACK. S_RX_ACK drives ACK as in REQ-018 and then returns to S_RX_BYTE.
REQ-023 temp_data changes after the snapshot SHALL NOT affect the bytes of the current transaction.
REQ-024 An scl edge and a START/STOP detected in the same cycle: START/STOP takes priority.

Reset
REQ-025 Reset SHALL force S_IDLE, release sda, clear busy/addr_match/read_done, set pointer=8'h00, clear the hold register and the bit counter, and preset the synchronizer flops to 1.
REQ-026 Reset asserted mid-transaction SHALL release sda on the first clock of reset and ignore the bus until the next START.

Structure
REQ-027 Package adt7420_pkg SHALL hold the state enum typedef, ADT7420_ADDR=7'h4B, I2C_ACK=1'b0 and I2C_NACK=1'b1.
REQ-028 Sub-module i2c_bus_sync SHALL contain the synchronizers plus the scl_rise, scl_fall, start_det and stop_det pulse outputs.
REQ-029 Target size is 150-300 lines of RTL; no clock dividers and no gated clocks.

Verification
REQ-030 Read: temp_data=16'h2880, master sends START, 0x97 (addr 0x4B, R), ACKs the MSB, NACKs the LSB -> responder ACKs the address, master reads 0x28 then 0x80, read_done pulses once, busy falls at STOP.
REQ-031 Mismatch: master addresses 0x48 -> sda never driven low, addr_match stays 0, state S_IGNORE until STOP.
REQ-032 Write: START, 0x96, 0x03, STOP -> ACK after each byte, pointer=8'h03.
REQ-033 Wrap and snapshot: temp_data changes to 16'h1234 after the address ACK; master ACKs 3 bytes -> reads 0x28, 0x80, 0x28.
REQ-034 Repeated START after the MSB, then 0x97 -> a new snapshot is taken and the MSB is resent; reset pulsed mid-LSB -> sda is z within 1 clock.
REQ-035 A checker SHALL confirm the sda value never changes while scl is high, except at START/STOP.
